// File: rtl/fp_multiplier_pipe.sv
// Three-stage pipelined floating-point multiplier with a valid/ready handshake.
// S1 unpacks and classifies the operands, S2 multiplies the significands, and
// S3 normalises, rounds (nearest, ties to even), packs and registers the result.
// A single global advance signal stalls every stage together under backpressure.
module fp_multiplier_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Result,
    output logic         flag_invalid,
    output logic         flag_overflow,
    output logic         flag_underflow
);

    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [XW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [XW-1:0] EXP_ONE = {{(XW-1){1'b0}}, 1'b1};
    localparam logic signed [XW-1:0] EXP_ZERO = {XW{1'b0}};
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        K_NORM = 2'd0,
        K_ZERO = 2'd1,
        K_INF  = 2'd2,
        K_NAN  = 2'd3
    } kind_t;

    logic advance_s;
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    // ---------------- S1: unpack and classify ----------------
    logic [EXP_W-1:0] ea_s, eb_s;
    logic [MAN_W-1:0] fa_s, fb_s;
    logic a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic signed [XW-1:0] exp_sum_s;
    kind_t kind_s;

    assign ea_s = A[W-2:MAN_W];
    assign eb_s = B[W-2:MAN_W];
    assign fa_s = A[MAN_W-1:0];
    assign fb_s = B[MAN_W-1:0];
    assign a_nan_s  = (&ea_s) && (|fa_s);
    assign b_nan_s  = (&eb_s) && (|fb_s);
    assign a_inf_s  = (&ea_s) && !(|fa_s);
    assign b_inf_s  = (&eb_s) && !(|fb_s);
    // Subnormal operands (exp=0, frac!=0) are flushed to zero here.
    assign a_zero_s = !(|ea_s);
    assign b_zero_s = !(|eb_s);
    assign exp_sum_s = $signed({2'b00, ea_s} + {2'b00, eb_s} - BIAS);

    // Special-case priority: NaN, inf*0, inf, zero, then the normal path.
    always_comb begin
        kind_s = K_NORM;
        if (a_nan_s || b_nan_s) begin
            kind_s = K_NAN;
        end else if ((a_inf_s && b_zero_s) || (a_zero_s && b_inf_s)) begin
            kind_s = K_NAN;
        end else if (a_inf_s || b_inf_s) begin
            kind_s = K_INF;
        end else if (a_zero_s || b_zero_s) begin
            kind_s = K_ZERO;
        end else begin
            kind_s = K_NORM;
        end
    end

    logic                 s1_valid_r, s1_sign_r;
    kind_t                s1_kind_r;
    logic [MAN_W:0]       s1_ma_r, s1_mb_r;
    logic signed [XW-1:0] s1_exp_r;

    // Stage 1 register: classified operands with hidden bits restored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_kind_r  <= K_ZERO;
            s1_ma_r    <= {(MAN_W+1){1'b0}};
            s1_mb_r    <= {(MAN_W+1){1'b0}};
            s1_exp_r   <= EXP_ZERO;
        end else if (advance_s) begin
            s1_valid_r <= in_valid;
            s1_sign_r  <= A[W-1] ^ B[W-1];
            s1_kind_r  <= kind_s;
            s1_ma_r    <= {1'b1, fa_s};
            s1_mb_r    <= {1'b1, fb_s};
            s1_exp_r   <= exp_sum_s;
        end
    end

    // ---------------- S2: significand multiply ----------------
    logic                 s2_valid_r, s2_sign_r;
    kind_t                s2_kind_r;
    logic [PW-1:0]        s2_prod_r;
    logic signed [XW-1:0] s2_exp_r;

    // Stage 2 register: full-width significand product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_sign_r  <= 1'b0;
            s2_kind_r  <= K_ZERO;
            s2_prod_r  <= {PW{1'b0}};
            s2_exp_r   <= EXP_ZERO;
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            s2_sign_r  <= s1_sign_r;
            s2_kind_r  <= s1_kind_r;
            s2_prod_r  <= {{(MAN_W+1){1'b0}}, s1_ma_r} * {{(MAN_W+1){1'b0}}, s1_mb_r};
            s2_exp_r   <= s1_exp_r;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic                 msb_s, guard_s, sticky_s, rnd_up_s, ovf_s, unf_s;
    logic [MAN_W-1:0]     frac_s;
    logic [MAN_W:0]       frac_rnd_s;
    logic signed [XW-1:0] exp_n_s, exp_f_s;
    logic [W-1:0]         res_s;
    logic                 inv_s, ovf_flag_s, unf_flag_s;

    assign msb_s    = s2_prod_r[PW-1];
    assign frac_s   = msb_s ? s2_prod_r[PW-2 -: MAN_W] : s2_prod_r[PW-3 -: MAN_W];
    assign guard_s  = msb_s ? s2_prod_r[MAN_W] : s2_prod_r[MAN_W-1];
    assign sticky_s = msb_s ? (|s2_prod_r[MAN_W-1:0]) : (|s2_prod_r[MAN_W-2:0]);
    assign exp_n_s  = msb_s ? (s2_exp_r + EXP_ONE) : s2_exp_r;
    assign rnd_up_s = guard_s && (sticky_s || frac_s[0]);
    assign frac_rnd_s = {1'b0, frac_s} + {{MAN_W{1'b0}}, rnd_up_s};
    // A carry out of the rounded fraction means 10.000..., i.e. fraction 0, exponent +1.
    assign exp_f_s  = frac_rnd_s[MAN_W] ? (exp_n_s + EXP_ONE) : exp_n_s;
    assign ovf_s    = (exp_f_s >= EXP_MAX);
    assign unf_s    = (exp_f_s <= EXP_ZERO);

    // Select the packed result and its flags from the operand class.
    always_comb begin
        res_s      = {W{1'b0}};
        inv_s      = 1'b0;
        ovf_flag_s = 1'b0;
        unf_flag_s = 1'b0;
        case (s2_kind_r)
            K_NAN: begin
                res_s = QNAN;
                inv_s = 1'b1;
            end
            K_INF: begin
                res_s = {s2_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            K_ZERO: begin
                res_s = {s2_sign_r, {(W-1){1'b0}}};
            end
            K_NORM: begin
                if (ovf_s) begin
                    res_s      = {s2_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    ovf_flag_s = 1'b1;
                end else if (unf_s) begin
                    res_s      = {s2_sign_r, {(W-1){1'b0}}};
                    unf_flag_s = 1'b1;
                end else begin
                    res_s = {s2_sign_r, exp_f_s[EXP_W-1:0], frac_rnd_s[MAN_W-1:0]};
                end
            end
            default: begin
                res_s = {W{1'b0}};
            end
        endcase
    end

    // Output register: result and flags are zero whenever out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            Result         <= {W{1'b0}};
            flag_invalid   <= 1'b0;
            flag_overflow  <= 1'b0;
            flag_underflow <= 1'b0;
        end else if (advance_s) begin
            out_valid      <= s2_valid_r;
            Result         <= s2_valid_r ? res_s : {W{1'b0}};
            flag_invalid   <= s2_valid_r && inv_s;
            flag_overflow  <= s2_valid_r && ovf_flag_s;
            flag_underflow <= s2_valid_r && unf_flag_s;
        end
    end

endmodule

// File: tb/tb_fp_multiplier_pipe.sv
// Directed self-checking bench for fp_multiplier_pipe in single precision.
module tb_fp_multiplier_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        flag_invalid;
    logic        flag_overflow;
    logic        flag_underflow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_multiplier_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .A             (A),
        .B             (B),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Result        (Result),
        .flag_invalid  (flag_invalid),
        .flag_overflow (flag_overflow),
        .flag_underflow(flag_underflow)
    );

    // Directed vectors: operands, hand-computed product, flags {invalid,overflow,underflow}.
    logic [31:0] va  [0:10] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'h3F800001, 32'hBF800000,
                                32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h7F7FFFFF, 32'h00800000,
                                32'h80800000};
    logic [31:0] vb  [0:10] = '{32'h40000000, 32'h40800000, 32'h3FC00000, 32'h3F800001, 32'h3F800000,
                                32'h00000000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'h3F000000,
                                32'h00000001};
    logic [31:0] vr  [0:10] = '{32'h40000000, 32'h41400000, 32'h40100000, 32'h3F800002, 32'hBF800000,
                                32'h7FC00000, 32'hFF800000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                                32'h80000000};
    logic [2:0]  vf  [0:10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b100, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000};
    string       vn  [0:10] = '{"basic_1x2", "basic_3x4", "round_1p5sq", "round_sticky", "round_neg",
                                "spec_inf_x_0", "spec_neginf", "spec_nan_in", "range_ovf", "range_unf",
                                "range_subnorm"};

    // Issue one op with out_ready=1 and wait (bounded) for its result.
    // lat counts rising edges from the accepting edge to out_valid; -1 on timeout.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic [2:0] fl, output int lat);
        A = a;
        B = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
        res = Result;
        fl  = {flag_invalid, flag_overflow, flag_underflow};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        A = 32'h0;
        B = 32'h0;
        #12;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (Result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 00000000", Result); end
        checks++;
        if ({flag_invalid, flag_overflow, flag_underflow} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b expected 000", {flag_invalid, flag_overflow, flag_underflow});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        for (int i = 0; i < 2; i++) begin
            do_op(va[i], vb[i], res, fl, lat);
            checks++;
            if (res !== vr[i]) begin failures++; $display("FAIL %s result: got %h expected %h", vn[i], res, vr[i]); end
            checks++;
            if (fl !== vf[i]) begin failures++; $display("FAIL %s flags: got %b expected %b", vn[i], fl, vf[i]); end
            checks++;
            if (lat !== 3) begin failures++; $display("FAIL %s latency: got %0d expected 3", vn[i], lat); end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        for (int i = 2; i < 5; i++) begin
            do_op(va[i], vb[i], res, fl, lat);
            checks++;
            if (res !== vr[i]) begin failures++; $display("FAIL %s result: got %h expected %h", vn[i], res, vr[i]); end
            checks++;
            if (fl !== vf[i]) begin failures++; $display("FAIL %s flags: got %b expected %b", vn[i], fl, vf[i]); end
        end
    endtask

    task automatic test_specials();
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        for (int i = 5; i < 8; i++) begin
            do_op(va[i], vb[i], res, fl, lat);
            checks++;
            if (res !== vr[i]) begin failures++; $display("FAIL %s result: got %h expected %h", vn[i], res, vr[i]); end
            checks++;
            if (fl !== vf[i]) begin failures++; $display("FAIL %s flags: got %b expected %b", vn[i], fl, vf[i]); end
        end
    endtask

    task automatic test_range();
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        for (int i = 8; i < 11; i++) begin
            do_op(va[i], vb[i], res, fl, lat);
            checks++;
            if (res !== vr[i]) begin failures++; $display("FAIL %s result: got %h expected %h", vn[i], res, vr[i]); end
            checks++;
            if (fl !== vf[i]) begin failures++; $display("FAIL %s flags: got %b expected %b", vn[i], fl, vf[i]); end
        end
    endtask

    // Six back-to-back ops, out_ready low during cycles 4..7 of the stream.
    task automatic test_backpressure();
        logic [31:0] sa [0:5] = '{32'h3F800000, 32'h40400000, 32'h3FC00000, 32'hBF800000, 32'hFF800000, 32'h40000000};
        logic [31:0] sb [0:5] = '{32'h40000000, 32'h40800000, 32'h3FC00000, 32'h3F800000, 32'h40000000, 32'h40000000};
        logic [31:0] se [0:5] = '{32'h40000000, 32'h41400000, 32'h40100000, 32'hBF800000, 32'hFF800000, 32'h40800000};
        int idx   = 0;
        int n_got = 0;
        logic exp_ov;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            in_valid  = (idx < 6);
            A         = sa[(idx < 6) ? idx : 0];
            B         = sb[(idx < 6) ? idx : 0];
            out_ready = !(cyc >= 4 && cyc <= 7);
            #1;
            exp_ov = (cyc >= 3 && cyc <= 12);
            checks++;
            if (out_valid !== exp_ov) begin
                failures++; $display("FAIL bp_out_valid cyc%0d: got %b expected %b", cyc, out_valid, exp_ov);
            end
            if (cyc >= 4 && cyc <= 7) begin
                checks++;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc%0d: got %b expected 0", cyc, in_ready); end
                checks++;
                if (Result !== se[1]) begin failures++; $display("FAIL bp_hold cyc%0d: got %h expected %h", cyc, Result, se[1]); end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (n_got < 6) begin
                    checks++;
                    if (Result !== se[n_got]) begin
                        failures++; $display("FAIL bp_order item%0d: got %h expected %h", n_got, Result, se[n_got]);
                    end
                end
                n_got++;
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) idx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (n_got !== 6) begin failures++; $display("FAIL bp_count: got %0d results expected 6", n_got); end
        checks++;
        if (idx !== 6) begin failures++; $display("FAIL bp_accepts: got %0d accepts expected 6", idx); end
    endtask

    // Async reset with three ops in flight, then a fresh op.
    task automatic test_reset_mid();
        logic [31:0] res;
        logic [2:0]  fl;
        int          lat;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            A = va[k];
            B = vb[k];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre_valid: got %b expected 1", out_valid); end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_async_valid: got %b expected 0", out_valid); end
        checks++;
        if (Result !== 32'h0) begin failures++; $display("FAIL rm_async_result: got %h expected 00000000", Result); end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_stale cyc%0d: got out_valid=%b expected 0", c, out_valid); end
            @(posedge clk);
            #1;
        end
        do_op(32'h40400000, 32'h40800000, res, fl, lat);
        checks++;
        if (lat !== 3) begin failures++; $display("FAIL rm_latency: got %0d expected 3", lat); end
        checks++;
        if (res !== 32'h41400000) begin failures++; $display("FAIL rm_result: got %h expected 41400000", res); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_range();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_multiplier_pipe.md
Name: fp_multiplier_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point multiplier. It is the clocked successor to the combinational single-precision FP_Multiplier.
- Accepts operand pairs through a valid/ready handshake and returns correctly rounded products three cycles later.
- Supports backpressure.
- Handles zero, infinity, NaN, overflow and underflow.
- Sits between operand-issue logic and the result writeback path in the FP datapath.

Parameters:
EXP_W, 8, exponent field width in bits
MAN_W, 23, stored mantissa (fraction) width in bits, hidden bit excluded
(word width W = 1 + EXP_W + MAN_W; bias = 2^(EXP_W-1) - 1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand pair A/B is valid this cycle
in_ready  output  1  block can accept an operand pair this cycle
A  input  W  operand A, packed sign|exponent|fraction
B  input  W  operand B, same format
out_valid  output  1  Result and flags are valid
out_ready  input  1  downstream accepts the result this cycle
Result  output  W  rounded product
flag_invalid  output  1  Result produced by inf*0 or NaN input
flag_overflow  output  1  Result saturated to infinity by exponent overflow
flag_underflow  output  1  true result below min normal, flushed to signed zero

Behaviour:
- Reset (asynchronous, immediate): all stage-valid bits 0, out_valid=0, Result=0, all flags=0. in_ready=1 from the first cycle after rst deasserts. Any operation in flight at reset is discarded without output.
- Pipeline: S1 unpack/classify, S2 mantissa multiply, S3 normalise/round/pack. Latency is exactly 3 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - Accept happens when in_valid && in_ready.
  - When advance=0, all stages hold their contents. Result and flags stay stable while out_valid && !out_ready.
  - Bubbles (invalid stages) propagate normally; no combinational path from in_valid to out_valid.
- Sign = sign(A) XOR sign(B) for all results except NaN.
- Subnormal inputs (exp=0, frac!=0) are treated as zero, with the sign preserved.
- Special cases, first match wins:
  - either operand NaN -> canonical quiet NaN (sign 0, exp all ones, frac MSB 1, rest 0), flag_invalid=1.
  - inf*0 or 0*inf -> canonical NaN, flag_invalid=1.
  - either operand inf -> signed inf.
  - either operand zero -> signed zero, no flags.
- Normal path:
  - Form a (MAN_W+1) x (MAN_W+1) product of the significands with the hidden bit.
  - exponent = eA + eB - bias, computed with EXP_W+2 signed bits.
  - If product MSB is set, shift right 1 and increment the exponent.
  - Round to nearest, ties to even, using guard bit + sticky OR of the remaining bits.
  - If rounding carries out of the mantissa, renormalise and increment the exponent again.
- Overflow (final exponent >= 2^EXP_W - 1): signed inf, flag_overflow=1.
- Underflow (final exponent <= 0): signed zero, flag_underflow=1. No subnormal outputs are produced.
- Flags are per-result, valid only with out_valid, and 0 otherwise.

Test Plan:
- Basic (single precision), 3 cycles after accept:
  - A=3F800000, B=40000000 -> Result=40000000.
  - A=40400000, B=40800000 -> Result=41400000.
  - All flags 0 for both.
- Rounding:
  - A=B=3FC00000 -> 40100000.
  - A=B=3F800001 -> 3F800002 (sticky rounds down the 2^-46 term).
  - A=BF800000, B=3F800000 -> BF800000.
- Specials:
  - A=7F800000, B=00000000 -> 7FC00000, flag_invalid=1.
  - A=FF800000, B=40000000 -> FF800000, no flags.
  - A=7FC00001, B=3F800000 -> 7FC00000, flag_invalid=1.
- Range:
  - A=7F7FFFFF, B=40000000 -> 7F800000, flag_overflow=1.
  - A=00800000, B=3F000000 -> 00000000, flag_underflow=1.
  - A=80800000, B=00000001 -> 80000000 (subnormal input treated as zero), no flags.
- Backpressure: stream 6 back-to-back pairs with out_ready=0 for cycles 4-7.
  - Result must hold stable and in_ready must be 0 during the stall.
  - All 6 results must come out in order with none lost or duplicated.
  - After release, throughput returns to 1 per cycle.
- Reset mid-operation: assert rst asynchronously while 3 ops are in flight.
  - out_valid and Result drop to 0 immediately.
  - No stale result appears after rst deasserts.
  - The first new operation completes with exactly 3-cycle latency.
